sound_pong: RTL and testbench

- Audio stage directly downstream of the ball-dynamics block; consumes its `code_sound[1:0]` and `mute` outputs.
- Drives a 1-bit square-wave speaker pin.
- Plays a fixed-length tone per event: ping (high tone), pong (low tone), go (low then high tone).
- A new sound starts on every change of `code_sound` to a non-stop value.

---
 rtl/sound_pong_pkg.sv | 20 ++
 rtl/tone_divider.sv | 30 +++
 rtl/sound_pong.sv | 82 ++++++++
 tb/tb_sound_pong.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pong_pkg.sv
// Shared sound codes and timing constants for the pong audio path.
// The ball-dynamics block drives code_sound using the same encoding.
package sound_pong_pkg;

    localparam int CLK_HZ = 12000000;

    typedef enum logic [1:0] {
        SND_STOP = 2'b00,
        SND_PONG = 2'b01,
        SND_PING = 2'b10,
        SND_GO   = 2'b11
    } sound_code_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_TONE1 = 2'b01,
        S_TONE2 = 2'b10
    } sound_state_t;

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: out toggles every `half` clocks while run is high.
// Dropping run for one cycle restarts the waveform from a low phase.
module tone_divider #(
    parameter int HW = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          run,
    input  logic [HW-1:0] half,
    output logic          out
);

    logic [HW-1:0] half_cnt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            half_cnt <= '0;
            out      <= 1'b0;
        end else if (!run) begin
            half_cnt <= '0;
            out      <= 1'b0;
        end else if (half_cnt == half - HW'(1)) begin
            half_cnt <= '0;
            out      <= ~out;
        end else begin
            half_cnt <= half_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/sound_pong.sv
// Event sound player: ping, pong or go (pong then ping) as fixed-length
// square-wave tones on a 1-bit speaker pin.
//
//   state   | meaning
//   S_IDLE  | silent, waiting for a new non-stop code
//   S_TONE1 | first segment: pong tone for pong/go, ping tone for ping
//   S_TONE2 | second segment of go: ping tone
module sound_pong
    import sound_pong_pkg::*;
#(
    parameter int HALF_PING = 6818,
    parameter int HALF_PONG = 13636,
    parameter int DUR_TONE  = 1200000,
    parameter int HW        = 16,
    parameter int DW        = 24
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] code_sound,
    input  logic       mute,
    output logic       speaker,
    output logic       busy
);

    if ((HALF_PING < 1) || ((HALF_PING >> HW) != 0) ||
        (HALF_PONG < 1) || ((HALF_PONG >> HW) != 0) ||
        (DUR_TONE  < 1) || ((DUR_TONE  >> DW) != 0)) begin : g_param_check
        $error("sound_pong: tone parameters do not fit their counters");
    end

    sound_state_t  state;
    logic [1:0]    code_q;
    logic [1:0]    sel;
    logic [DW-1:0] dur_cnt;
    logic          start;
    logic          seg_end;
    logic          run;
    logic [HW-1:0] half;

    assign start   = (code_sound != code_q) && (code_sound != SND_STOP) && !mute;
    assign seg_end = (dur_cnt == DW'(DUR_TONE - 1));
    assign busy    = (state != S_IDLE);

    // Holding run low on start, mute and segment end restarts the divider low.
    assign run  = busy && !mute && !start && !seg_end;
    assign half = ((state == S_TONE1) && (sel != SND_PING)) ? HW'(HALF_PONG) : HW'(HALF_PING);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= S_IDLE;
            code_q  <= SND_STOP;
            sel     <= SND_STOP;
            dur_cnt <= '0;
        end else begin
            code_q <= code_sound;
            if (mute) begin
                state   <= S_IDLE;
                dur_cnt <= '0;
            end else if (start) begin
                state   <= S_TONE1;
                sel     <= code_sound;
                dur_cnt <= '0;
            end else if (state != S_IDLE) begin
                if (seg_end) begin
                    dur_cnt <= '0;
                    state   <= ((state == S_TONE1) && (sel == SND_GO)) ? S_TONE2 : S_IDLE;
                end else begin
                    dur_cnt <= dur_cnt + DW'(1);
                end
            end
        end
    end

    tone_divider #(.HW(HW)) u_tone (
        .clk  (clk),
        .clr  (clr),
        .run  (run),
        .half (half),
        .out  (speaker)
    );

endmodule

// File: tb/tb_sound_pong.sv
// Self-checking bench for sound_pong with short tones (ping 2, pong 4, 16-cycle segments).
module tb_sound_pong;

    localparam int HPING = 2;
    localparam int HPONG = 4;
    localparam int DUR   = 16;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] code_sound = 2'b00;
    logic       mute = 1'b0;
    logic       speaker;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    sound_pong #(
        .HALF_PING (HPING),
        .HALF_PONG (HPONG),
        .DUR_TONE  (DUR),
        .HW        (16),
        .DW        (24)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .code_sound (code_sound),
        .mute       (mute),
        .speaker    (speaker),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of remaining tone segments (half-period of each)
    // and the position inside the current segment.
    int         seg_q[$];
    int         pos;
    logic [1:0] prev_code;
    logic       exp_spk;
    logic       exp_busy;

    task automatic model_reset();
        seg_q.delete();
        pos       = 0;
        prev_code = 2'b00;
    endtask

    task automatic model_edge(input logic [1:0] c, input logic m);
        bit st;
        st = (c != prev_code) && (c != 2'b00) && !m;
        prev_code = c;
        if (m) begin
            seg_q.delete();
        end else if (st) begin
            seg_q.delete();
            pos = 0;
            case (c)
                2'b11: begin seg_q.push_back(HPONG); seg_q.push_back(HPING); end
                2'b01: seg_q.push_back(HPONG);
                default: seg_q.push_back(HPING);
            endcase
        end else if (seg_q.size() > 0) begin
            pos++;
            if (pos == DUR) begin
                void'(seg_q.pop_front());
                pos = 0;
            end
        end
    endtask

    task automatic model_outputs();
        exp_busy = (seg_q.size() > 0);
        exp_spk  = exp_busy ? (((pos / seg_q[0]) % 2) == 1) : 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, update the model at the
    // rising edge, compare on the next falling edge.
    task automatic step(input logic [1:0] c, input logic m);
        code_sound = c;
        mute       = m;
        @(posedge clk);
        model_edge(c, m);
        @(negedge clk);
        model_outputs();
        check("model_speaker", int'(speaker), int'(exp_spk));
        check("model_busy", int'(busy), int'(exp_busy));
    endtask

    task automatic run_busy(input logic [1:0] c, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step(c, 1'b0);
            if (busy) cnt++;
        end
    endtask

    typedef struct {
        logic [1:0] code;
        logic       mute;
        logic       spk;
        logic       bsy;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        logic [19:0] ping_spk;
        logic [19:0] ping_busy;
        int          cnt;

        // Ping from idle: speaker toggles every 2 cycles for 16 cycles, then
        // stays silent while the code is held.
        ping_spk  = 20'b0000_1100_1100_1100_1100;
        ping_busy = 20'b0000_1111_1111_1111_1111;
        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v.code = 2'b10;
            v.mute = 1'b0;
            v.spk  = ping_spk[i];
            v.bsy  = ping_busy[i];
            tbl.push_back(v);
        end

        // Reset held with a ping code present.
        model_reset();
        clr        = 1'b0;
        code_sound = 2'b10;
        repeat (3) @(negedge clk);
        check("reset_speaker", int'(speaker), 0);
        check("reset_busy", int'(busy), 0);
        clr = 1'b1;
        run_busy(2'b10, 20, cnt);
        check("post_reset_ping_busy_cycles", cnt, 16);

        // Table-driven ping.
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);
        foreach (tbl[i]) begin
            step(tbl[i].code, tbl[i].mute);
            check($sformatf("tbl_speaker[%0d]", i), int'(speaker), int'(tbl[i].spk));
            check($sformatf("tbl_busy[%0d]", i), int'(busy), int'(tbl[i].bsy));
        end

        // Go: pong segment then ping segment.
        step(2'b00, 1'b0);
        cnt = 0;
        for (int i = 0; i < 36; i++) begin
            step(2'b11, 1'b0);
            if (busy) cnt++;
            if (i == 6)  check("go_pong_phase", int'(speaker), 1);
            if (i == 16) check("go_boundary_speaker", int'(speaker), 0);
            if (i == 18) check("go_ping_phase", int'(speaker), 1);
        end
        check("go_busy_cycles", cnt, 32);

        // Retrigger ping -> pong at cycle 5.
        step(2'b00, 1'b0);
        for (int i = 0; i < 5; i++) step(2'b10, 1'b0);
        step(2'b01, 1'b0);
        check("retrig_speaker", int'(speaker), 0);
        check("retrig_busy", int'(busy), 1);
        cnt = 1;
        for (int i = 1; i < 20; i++) begin
            step(2'b01, 1'b0);
            if (busy) cnt++;
            if (i == 4) check("retrig_pong_phase", int'(speaker), 1);
        end
        check("retrig_busy_cycles", cnt, 16);

        // Mute pong at cycle 7, unmute with unchanged code, then re-issue.
        step(2'b00, 1'b0);
        for (int i = 0; i < 7; i++) step(2'b01, 1'b0);
        check("pre_mute_speaker", int'(speaker), 1);
        step(2'b01, 1'b1);
        check("mute_speaker", int'(speaker), 0);
        check("mute_busy", int'(busy), 0);
        step(2'b01, 1'b1);
        run_busy(2'b01, 4, cnt);
        check("unmute_stays_idle", cnt, 0);
        step(2'b00, 1'b0);
        step(2'b01, 1'b0);
        check("replay_pong_busy", int'(busy), 1);
        repeat (18) step(2'b01, 1'b0);

        // Async reset in the second segment of go, between clock edges.
        step(2'b00, 1'b0);
        for (int i = 0; i < 19; i++) step(2'b11, 1'b0);
        check("pre_reset_speaker", int'(speaker), 1);
        #2;
        clr = 1'b0;
        #1;
        check("async_reset_speaker", int'(speaker), 0);
        check("async_reset_busy", int'(busy), 0);
        code_sound = 2'b00;
        model_reset();
        @(negedge clk);
        clr = 1'b1;

        // Code dropping to stop mid-ping lets the ping finish.
        step(2'b10, 1'b0);
        cnt = 1;
        for (int i = 0; i < 3; i++) begin
            step(2'b10, 1'b0);
            if (busy) cnt++;
        end
        for (int i = 0; i < 16; i++) begin
            step(2'b00, 1'b0);
            if (busy) cnt++;
        end
        check("stop_code_no_abort", cnt, 16);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] c;
            logic       m;
            c = code_sound;
            if ($urandom_range(0, 19) == 0) c = 2'($urandom_range(0, 3));
            m = mute;
            if ($urandom_range(0, 29) == 0) m = ~mute;
            step(c, m);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
